// File: rtl/plr_pkg.sv
// Shared types and constants for the elastic pipeline register (plr) blocks.
package plr_pkg;

  typedef enum logic [1:0] {
    PLR_EMPTY = 2'd0,
    PLR_ONE   = 2'd1,
    PLR_TWO   = 2'd2
  } plr_state_e;

  // Default bubbles: all-zero payload, or a RISC-V NOP (addi x0,x0,0) for instruction fields.
  localparam logic [31:0] PLR_BUBBLE_ZERO = 32'h0000_0000;
  localparam logic [31:0] PLR_BUBBLE_NOP  = 32'h0000_0013;

  function automatic logic [1:0] plr_level(input plr_state_e s);
    case (s)
      PLR_ONE: return 2'd1;
      PLR_TWO: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/plr_sat_cnt.sv
// Saturating up-counter for performance events; sticks at all-ones until reset.
module plr_sat_cnt
  import plr_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/plr_skid.sv
// Elastic pipeline register with a two-entry skid buffer, flush-to-bubble and a
// saturating downstream stall counter. All outputs come straight from registers.
module plr_skid
  import plr_pkg::*;
#(
  parameter int               WIDTH  = 96,
  parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}},
  parameter int               CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       level,
  output logic [CNT_W-1:0] stall_cnt
);

  plr_state_e       state_reg, state_next;
  logic [WIDTH-1:0] main_reg, main_next;
  logic [WIDTH-1:0] skid_reg;
  logic             skid_load;
  logic             out_valid_reg, in_ready_reg;
  logic [1:0]       level_reg;
  logic             in_fire, out_fire;

  assign in_fire  = in_valid & in_ready_reg;
  assign out_fire = out_valid_reg & out_ready;

  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_load  = 1'b0;
    if (flush) begin
      state_next = PLR_EMPTY;
      main_next  = BUBBLE;
    end else begin
      case (state_reg)
        PLR_EMPTY: begin
          if (in_fire) begin
            state_next = PLR_ONE;
            main_next  = in_data;
          end
        end
        PLR_ONE: begin
          if (in_fire && out_fire) begin
            main_next = in_data;
          end else if (in_fire) begin
            state_next = PLR_TWO;
            skid_load  = 1'b1;
          end else if (out_fire) begin
            state_next = PLR_EMPTY;
            main_next  = BUBBLE;
          end
        end
        PLR_TWO: begin
          if (out_fire) begin
            state_next = PLR_ONE;
            main_next  = skid_reg;
          end
        end
        default: begin
          state_next = PLR_EMPTY;
          main_next  = BUBBLE;
        end
      endcase
    end
  end

  // Handshake outputs are decoded from the next state so they are plain flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= PLR_EMPTY;
      main_reg      <= BUBBLE;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b1;
      level_reg     <= 2'd0;
    end else begin
      state_reg     <= state_next;
      main_reg      <= main_next;
      out_valid_reg <= (state_next != PLR_EMPTY);
      in_ready_reg  <= (state_next != PLR_TWO);
      level_reg     <= plr_level(state_next);
    end
  end

  // Skid content is only meaningful in PLR_TWO, so it needs no reset.
  always_ff @(posedge clk) begin
    if (skid_load) begin
      skid_reg <= in_data;
    end
  end

  plr_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk(clk),
    .rst(rst),
    .inc(out_valid_reg & ~out_ready),
    .cnt(stall_cnt)
  );

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = main_reg;
  assign level     = level_reg;

endmodule

// File: tb/tb_plr_skid.sv
// Scoreboard bench for plr_skid: a driver queues accepted beats, a monitor pops them on out_fire.
module tb_plr_skid;
  import plr_pkg::*;

  localparam int          WIDTH  = 32;
  localparam int          CNT_W  = 4;
  localparam logic [31:0] BUBBLE = PLR_BUBBLE_NOP;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       level;
  logic [CNT_W-1:0] stall_cnt;

  int checks = 0;
  int failures = 0;
  logic [31:0] sb[$];

  plr_skid #(
    .WIDTH(WIDTH),
    .BUBBLE(BUBBLE),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .level(level),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the edge; queue the beat if it will be accepted.
  task automatic cyc(input logic v, input logic [31:0] d, input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    if (v && in_ready && !fl) sb.push_back(d);
  endtask

  // Monitor: order, bubble value and stall stability, sampled on the falling edge.
  logic        prev_stall = 1'b0;
  logic        prev_flush = 1'b0;
  logic [31:0] prev_data = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      prev_flush = 1'b0;
    end else begin
      if (prev_stall && !prev_flush) begin
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_data", out_data, prev_data);
      end
      if (!out_valid) chk("bubble_data", out_data, BUBBLE);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=%h required=none", out_data);
        end else begin
          chk("beat_order", out_data, sb.pop_front());
        end
      end
      if (flush) sb.delete();
      prev_stall = out_valid && !out_ready;
      prev_flush = flush;
      prev_data  = out_data;
    end
  end

  initial begin
    @(posedge clk);
    #2 rst = 1'b0;

    // Async reset while holding two beats.
    cyc(1'b1, 32'hA0, 1'b0, 1'b0);
    cyc(1'b1, 32'hB0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("pre_rst_level", {30'd0, level}, 32'd2);
    chk("pre_rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("pre_rst_stall", {28'd0, stall_cnt}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, BUBBLE);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_level", {30'd0, level}, 32'd0);
    chk("rst_stall", {28'd0, stall_cnt}, 32'd0);
    sb.delete();
    @(posedge clk);
    #2 rst = 1'b0;

    // Streaming 1..8 with out_ready held high.
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, i, 1'b1, 1'b0);
      @(negedge clk);
      if (i == 1) begin
        chk("stream_level0", {30'd0, level}, 32'd0);
      end else begin
        chk("stream_level", {30'd0, level}, 32'd1);
        chk("stream_data", out_data, i - 1);
      end
    end
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("stream_last", out_data, 32'd8);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("stream_empty", {30'd0, level}, 32'd0);
    chk("stream_stall", {28'd0, stall_cnt}, 32'd0);

    // Backpressure: A, B fill the buffer, C waits upstream for three stalled cycles.
    cyc(1'b1, 32'hA, 1'b0, 1'b0);
    cyc(1'b1, 32'hB, 1'b0, 1'b0);
    cyc(1'b1, 32'hC, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_level2", {30'd0, level}, 32'd2);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_head", out_data, 32'hA);
    cyc(1'b1, 32'hC, 1'b0, 1'b0);
    cyc(1'b1, 32'hC, 1'b1, 1'b0);
    @(negedge clk);
    chk("bp_stall_peak", {28'd0, stall_cnt}, 32'd3);
    cyc(1'b1, 32'hC, 1'b1, 1'b0);
    @(negedge clk);
    chk("bp_after_pop", {30'd0, level}, 32'd1);
    chk("bp_second", out_data, 32'hB);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("bp_third", out_data, 32'hC);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("bp_drained", {30'd0, level}, 32'd0);
    chk("bp_stall", {28'd0, stall_cnt}, 32'd3);

    // Flush at level 2 with D offered and out_ready high: D must never appear.
    cyc(1'b1, 32'h50, 1'b0, 1'b0);
    cyc(1'b1, 32'h51, 1'b0, 1'b0);
    cyc(1'b1, 32'hD, 1'b1, 1'b1);
    @(negedge clk);
    chk("fl2_level", {30'd0, level}, 32'd2);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("fl2_out_valid", {31'd0, out_valid}, 32'd0);
    chk("fl2_level0", {30'd0, level}, 32'd0);
    chk("fl2_stall", {28'd0, stall_cnt}, 32'd4);

    // Flush at level 1 with a genuine in_fire and out_fire in the same cycle.
    cyc(1'b1, 32'h60, 1'b0, 1'b0);
    cyc(1'b1, 32'hE, 1'b1, 1'b1);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("fl1_out_valid", {31'd0, out_valid}, 32'd0);
    chk("fl1_level0", {30'd0, level}, 32'd0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);

    // Saturation: one beat held for 20 stalled cycles, 4-bit counter stops at 15.
    cyc(1'b1, 32'h77, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("sat_value", {28'd0, stall_cnt}, 32'd15);
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("sat_after_flush", {28'd0, stall_cnt}, 32'd15);
    chk("sat_flushed_level", {30'd0, level}, 32'd0);

    // Random valid/ready/flush with the monitor checking order and stability.
    for (int i = 0; i < 10000; i++) begin
      cyc(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 63) == 0));
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("drain_empty", sb.size(), 32'd0);
    chk("drain_level", {30'd0, level}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
